// File: rtl/amp_result_collector_pkg.sv
// Purpose: shared types and helpers for the amplifier result collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: word widths (aliases of the shared defines), result word struct,
// sequence-number increment helper.
`include "param_def.v"

package amp_result_collector_pkg;

  localparam int NO_W   = `NO_WIDTH;
  localparam int RES_W  = `RES_WIDTH;
  localparam int DATA_W = `RD_DATA_WIDTH;

  // Result word as it travels on the bus: sequence number in the upper bits.
  typedef struct packed {
    logic [NO_W-1:0]  no;
    logic [RES_W-1:0] res;
  } rd_word_t;

  // Next expected sequence number; wraps naturally at 2^NO_W.
  function automatic logic [NO_W-1:0] next_no(input logic [NO_W-1:0] no);
    return no + 1'b1;
  endfunction

endpackage

// File: rtl/amp_result_collector_if.sv
// Purpose: bundles the collector's data/handshake/status signals.
// Latency: n/a (wiring only).
// Backpressure: source side has none; consumer side is valid/ready.
// Ports: master = producer/consumer side (drives inputs, observes outputs),
//        slave  = collector side.
interface amp_result_collector_if
  import amp_result_collector_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                 in_val_i;
  logic [DATA_W-1:0]    in_data_i;
  logic                 out_rdy_i;
  logic                 clr_i;
  logic                 out_val_o;
  logic [NO_W-1:0]      out_no_o;
  logic [RES_W-1:0]     out_res_o;
  logic [LVL_W-1:0]     level_o;
  logic                 overflow_o;
  logic                 seq_err_o;
  logic [CNT_WIDTH-1:0] drop_cnt_o;
  logic [CNT_WIDTH-1:0] err_cnt_o;

  modport master (
    output in_val_i, in_data_i, out_rdy_i, clr_i,
    input  out_val_o, out_no_o, out_res_o, level_o,
           overflow_o, seq_err_o, drop_cnt_o, err_cnt_o
  );

  modport slave (
    input  in_val_i, in_data_i, out_rdy_i, clr_i,
    output out_val_o, out_no_o, out_res_o, level_o,
           overflow_o, seq_err_o, drop_cnt_o, err_cnt_o
  );

endinterface

// File: rtl/amp_sync_fifo.sv
// Purpose: show-ahead synchronous FIFO storage with pointers and occupancy.
// Latency: a word pushed at edge N is visible on rdata after edge N.
// Backpressure: none internally; caller must not push when full without a pop
//               nor pop when empty.
// Ports: clk, rst (sync, active-high), push/pop strobes, wdata in,
//        rdata (head entry, combinational from storage), level (occupancy).
module amp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;

  // DEPTH is a power of two, so pointer wrap is just natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage has no reset. When full with push+pop, wr_ptr == rd_ptr: the head
  // is read out this cycle and the slot is refilled, becoming the tail.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign level = level_q;

endmodule

// File: rtl/param_def.v
// Shared word-format widths for the amplifier result path.
// NO_WIDTH: per-result sequence number, RES_WIDTH: result payload,
// RD_DATA_WIDTH: packed result word {no, res}.
`ifndef PARAM_DEF_V
`define PARAM_DEF_V
`define NO_WIDTH      8
`define RES_WIDTH     16
`define RD_DATA_WIDTH 24
`endif

// File: rtl/amp_result_collector.sv
// Purpose: buffers amplifier results, tracks sequence-number continuity and
//          keeps drop/gap statistics.
// Latency: 1 cycle from in_val_i to out_val_o (show-ahead head).
// Backpressure: none toward the source; words arriving while full without a
//               simultaneous pop are dropped and counted.
// Ports: clk_i, rst_i (sync, active-high), bus (slave side of
//        amp_result_collector_if: input word, consumer ready, clear, head
//        entry, level, sticky flags, saturating counters).
module amp_result_collector
  import amp_result_collector_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  amp_result_collector_if.slave   bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [LW-1:0]     level;
  logic [DATA_W-1:0] head_dat;
  rd_word_t          head;
  logic [NO_W-1:0]   in_no;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;
  logic              gap;

  logic              first;
  logic [NO_W-1:0]   exp_no;
  logic              overflow;
  logic              seq_err;
  logic [CNT_WIDTH-1:0] drop_cnt;
  logic [CNT_WIDTH-1:0] err_cnt;

  assign in_no = bus.in_data_i[RES_W +: NO_W];
  assign full  = (level == LW'(DEPTH));

  // No handshake is reported while reset is applied.
  assign pop  = bus.out_val_o && bus.out_rdy_i && !rst_i;
  // When full, a same-cycle pop frees the slot for the incoming word.
  assign push = bus.in_val_i && (!full || pop) && !rst_i;
  assign drop = bus.in_val_i && !push;
  // Dropped words still advance the tracker, so gaps are judged on every input.
  assign gap  = bus.in_val_i && !first && (in_no != exp_no);

  amp_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_data_i),
    .rdata (head_dat),
    .level (level)
  );

  assign head          = rd_word_t'(head_dat);
  assign bus.out_val_o = (level != '0);
  assign bus.out_no_o  = head.no;
  assign bus.out_res_o = head.res;
  assign bus.level_o   = level;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first    <= 1'b1;
      exp_no   <= '0;
      overflow <= 1'b0;
      seq_err  <= 1'b0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (bus.in_val_i) begin
        first  <= 1'b0;
        exp_no <= next_no(in_no);
      end
      if (bus.clr_i) begin
        // Clear wins over any event this cycle; a coincident input becomes
        // the new tracker reference (first dropped above), otherwise re-arm.
        overflow <= 1'b0;
        seq_err  <= 1'b0;
        drop_cnt <= '0;
        err_cnt  <= '0;
        if (!bus.in_val_i) first <= 1'b1;
      end else begin
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
        end
        if (gap) begin
          seq_err <= 1'b1;
          if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.overflow_o = overflow;
  assign bus.seq_err_o  = seq_err;
  assign bus.drop_cnt_o = drop_cnt;
  assign bus.err_cnt_o  = err_cnt;

endmodule

// File: tb/tb_amp_result_collector.sv
// Purpose: self-checking bench for amp_result_collector: queue-based reference
// model compared every cycle, plus directed literal expectations.
module tb_amp_result_collector;
  import amp_result_collector_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amp_result_collector_if #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

  amp_result_collector #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  rd_word_t        mq[$];
  int              m_drop = 0;
  int              m_err  = 0;
  bit              m_ovf  = 1'b0;
  bit              m_serr = 1'b0;
  bit              m_first = 1'b1;
  logic [NO_W-1:0] m_exp = '0;
  rd_word_t        m_w;
  bit              m_pop;
  bit              m_push;

  always @(posedge clk) begin
    m_w = rd_word_t'(bus.in_data_i);
    if (rst) begin
      mq.delete();
      m_drop = 0; m_err = 0; m_ovf = 0; m_serr = 0; m_first = 1;
    end else begin
      m_pop  = (mq.size() != 0) && bus.out_rdy_i;
      m_push = bus.in_val_i && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_w);
      if (bus.clr_i) begin
        m_drop = 0; m_err = 0; m_ovf = 0; m_serr = 0;
        m_first = !bus.in_val_i;
        if (bus.in_val_i) m_exp = m_w.no + 1'b1;
      end else if (bus.in_val_i) begin
        if (!m_push) begin
          m_ovf = 1;
          if (m_drop < CMAX) m_drop++;
        end
        if (!m_first && (m_w.no != m_exp)) begin
          m_serr = 1;
          if (m_err < CMAX) m_err++;
        end
        m_first = 0;
        m_exp = m_w.no + 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_val",  bus.out_val_o, (mq.size() != 0));
      check("level",    bus.level_o, mq.size());
      if (mq.size() != 0) begin
        check("out_no",  bus.out_no_o, mq[0].no);
        check("out_res", bus.out_res_o, mq[0].res);
      end
      check("overflow", bus.overflow_o, m_ovf);
      check("seq_err",  bus.seq_err_o, m_serr);
      check("drop_cnt", bus.drop_cnt_o, m_drop);
      check("err_cnt",  bus.err_cnt_o, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int no, input int res, input bit rdy, input bit clr);
    bus.in_val_i  = v;
    bus.in_data_i = {NO_W'(no), RES_W'(res)};
    bus.out_rdy_i = rdy;
    bus.clr_i     = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_val_i  = 1'b0;
    bus.in_data_i = '0;
    bus.out_rdy_i = 1'b0;
    bus.clr_i     = 1'b0;

    // Reset
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk_en = 1'b1;
    drive(1, 3, 3, 1, 0);
    check("rst_out_val", bus.out_val_o, 0);
    check("rst_level",   bus.level_o, 0);
    check("rst_flags",   {bus.overflow_o, bus.seq_err_o}, 0);
    check("rst_cnts",    {bus.drop_cnt_o, bus.err_cnt_o}, 0);
    rst = 1'b0;

    // In-order pass-through, 1-cycle latency
    for (int k = 0; k < 4; k++) begin
      drive(1, k, 5 * k, 1, 0);
      check("pass_val",   bus.out_val_o, 1);
      check("pass_no",    bus.out_no_o, k);
      check("pass_res",   bus.out_res_o, 5 * k);
      check("pass_level", bus.level_o, 1);
    end
    drive(0, 0, 0, 1, 0);
    check("pass_empty", bus.out_val_o, 0);
    check("pass_serr",  bus.seq_err_o, 0);

    // Overflow: DEPTH+2 inputs with consumer stalled
    for (int k = 4; k < 4 + DEPTH + 2; k++) drive(1, k, 100 + k, 0, 0);
    check("ovf_level", bus.level_o, 8);
    check("ovf_flag",  bus.overflow_o, 1);
    check("ovf_drop",  bus.drop_cnt_o, 2);
    check("ovf_serr",  bus.seq_err_o, 0);
    for (int k = 0; k < DEPTH; k++) begin
      check("ovf_drain_no",  bus.out_no_o, 4 + k);
      check("ovf_drain_res", bus.out_res_o, 104 + k);
      drive(0, 0, 0, 1, 0);
    end
    check("ovf_drained", bus.level_o, 0);

    // Full FIFO with simultaneous push and pop
    for (int k = 14; k < 22; k++) drive(1, k, 100 + k, 0, 0);
    drive(1, 22, 222, 1, 0);
    check("full_pp_level", bus.level_o, 8);
    check("full_pp_drop",  bus.drop_cnt_o, 2);
    for (int k = 0; k < DEPTH; k++) begin
      check("full_pp_no", bus.out_no_o, 15 + k);
      drive(0, 0, 0, 1, 0);
    end

    // Drop counter saturation
    for (int k = 23; k < 51; k++) drive(1, k, k, 0, 0);
    check("drop_sat", bus.drop_cnt_o, CMAX);
    for (int k = 0; k < DEPTH; k++) drive(0, 0, 0, 1, 0);
    check("sat_drained", bus.level_o, 0);

    // Sequence gap detection
    drive(0, 0, 0, 1, 1);
    check("clr_drop", bus.drop_cnt_o, 0);
    check("clr_ovf",  bus.overflow_o, 0);
    drive(1, 10, 1, 1, 0);
    drive(1, 11, 2, 1, 0);
    check("gap_before", bus.seq_err_o, 0);
    drive(1, 13, 3, 1, 0);
    check("gap_serr", bus.seq_err_o, 1);
    check("gap_cnt",  bus.err_cnt_o, 1);

    // Sequence wrap 254,255,0 is not a gap
    drive(0, 0, 0, 1, 1);
    drive(1, 254, 4, 1, 0);
    drive(1, 255, 5, 1, 0);
    drive(1, 0, 6, 1, 0);
    check("wrap_serr", bus.seq_err_o, 0);
    check("wrap_cnt",  bus.err_cnt_o, 0);

    // Error counter saturation: repeated no=0 (expected 1 each time)
    for (int k = 0; k < 20; k++) drive(1, 0, k, 1, 0);
    check("err_sat", bus.err_cnt_o, CMAX);

    // Clear coinciding with an input; that input seeds the tracker
    drive(1, 7, 7, 1, 1);
    check("clrin_err",  bus.err_cnt_o, 0);
    check("clrin_serr", bus.seq_err_o, 0);
    drive(1, 8, 8, 1, 0);
    check("clrin_next_err",  bus.err_cnt_o, 0);
    check("clrin_next_serr", bus.seq_err_o, 0);
    check("clrin_next_drop", bus.drop_cnt_o, 0);
    drive(0, 0, 0, 1, 0);

    // Clear does not flush the FIFO
    drive(1, 9, 9, 0, 0);
    drive(1, 10, 10, 0, 0);
    drive(1, 11, 11, 0, 0);
    drive(0, 0, 0, 0, 1);
    check("clr_noflush", bus.level_o, 3);
    check("clr_head",    bus.out_no_o, 9);

    // Mid-stream reset discards contents
    rst = 1'b1;
    drive(1, 12, 12, 1, 0);
    check("midrst_val",   bus.out_val_o, 0);
    check("midrst_level", bus.level_o, 0);
    rst = 1'b0;
    drive(1, 99, 1, 1, 0);
    check("post_rst_no",   bus.out_no_o, 99);
    check("post_rst_serr", bus.seq_err_o, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
